// File: rtl/rtc_access_scheduler.sv
// Single-transfer scheduler in front of the RTC bus engine: IRQ service > user write > refresh burst.
// Define RTC_SCHED_TIMEOUT_EN to add a WAIT watchdog with sticky err_o and retry of the aborted request.
module rtc_access_scheduler #(
    parameter int unsigned REFRESH_CYCLES = 10_000_000,
    parameter logic [7:0]  IRQ_ADDR       = 8'h00,
    parameter logic [7:0]  IRQ_DATA       = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wr_req_i,
    input  logic [7:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    output logic       wr_ack_o,
    input  logic       irq_i,
    output logic       xfer_start_o,
    output logic       xfer_rw_o,
    output logic [7:0] xfer_addr_o,
    output logic [7:0] xfer_wdata_o,
    input  logic       xfer_done_i,
    input  logic [7:0] xfer_rdata_i,
    output logic       rd_valid_o,
    output logic [3:0] rd_index_o,
    output logic [7:0] rd_data_o,
    output logic       irq_flag_o,
    output logic       busy_o,
    output logic       err_o
);
    localparam int unsigned     CNT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    if (REFRESH_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("rtc_access_scheduler: REFRESH_CYCLES and TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
    typedef enum logic [1:0] {REQ_IRQ, REQ_WR, REQ_RD} req_e;

    state_e           state_q;
    req_e             req_q;
    logic             xfer_start_q, xfer_rw_q, wr_ack_q, rd_valid_q;
    logic [7:0]       xfer_addr_q, xfer_wdata_q, rd_data_q;
    logic [3:0]       rd_index_q;
    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic             refresh_pend_q, refresh_pend_d;
    logic [3:0]       burst_idx_q, burst_idx_d;
    logic             irq_pend_q, irq_pend_d;
    logic             irq_flag_q, irq_flag_d;
    logic             irq_meta_q, irq_sync_q, irq_prev_q;

    logic       wrap, irq_rise, done_evt;
    logic       grant_valid, grant_rw;
    req_e       grant_req;
    logic [7:0] grant_addr, grant_wdata, rd_addr;

    assign wrap     = (refresh_cnt_q == CNT_LAST);
    assign irq_rise = irq_sync_q & ~irq_prev_q;
    assign done_evt = (state_q == S_WAIT) && xfer_done_i;
    assign rd_addr  = (burst_idx_q < 4'd6) ? 8'h21 + {4'h0, burst_idx_q}
                                           : 8'h3B + {4'h0, burst_idx_q};

    always_comb begin
        grant_valid = 1'b1;
        grant_req   = REQ_RD;
        grant_rw    = 1'b1;
        grant_addr  = rd_addr;
        grant_wdata = 8'h00;
        if (irq_pend_q) begin
            grant_req   = REQ_IRQ;
            grant_rw    = 1'b0;
            grant_addr  = IRQ_ADDR;
            grant_wdata = IRQ_DATA;
        end else if (wr_req_i) begin
            grant_req   = REQ_WR;
            grant_rw    = 1'b0;
            grant_addr  = wr_addr_i;
            grant_wdata = wr_data_i;
        end else if (!refresh_pend_q) begin
            grant_valid = 1'b0;
        end
    end

    // Completion is applied before the wrap so a wrap in the finishing cycle re-arms a fresh burst.
    always_comb begin
        refresh_pend_d = refresh_pend_q;
        burst_idx_d    = burst_idx_q;
        irq_pend_d     = irq_pend_q;
        irq_flag_d     = irq_flag_q;
        refresh_cnt_d  = wrap ? '0 : refresh_cnt_q + CNT_W'(1);
        if (done_evt) begin
            case (req_q)
                REQ_IRQ: begin
                    irq_pend_d = 1'b0;
                    irq_flag_d = 1'b1;
                end
                REQ_RD: begin
                    if (burst_idx_q == 4'd8) begin
                        refresh_pend_d = 1'b0;
                        irq_flag_d     = 1'b0;
                        burst_idx_d    = 4'd0;
                    end else begin
                        burst_idx_d = burst_idx_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
        if (irq_rise) irq_pend_d = 1'b1;
        if (wrap && !refresh_pend_d) begin
            refresh_pend_d = 1'b1;
            burst_idx_d    = 4'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            refresh_cnt_q  <= '0;
            refresh_pend_q <= 1'b0;
            burst_idx_q    <= 4'd0;
            irq_pend_q     <= 1'b0;
            irq_flag_q     <= 1'b0;
            irq_meta_q     <= 1'b0;
            irq_sync_q     <= 1'b0;
            irq_prev_q     <= 1'b0;
        end else begin
            refresh_cnt_q  <= refresh_cnt_d;
            refresh_pend_q <= refresh_pend_d;
            burst_idx_q    <= burst_idx_d;
            irq_pend_q     <= irq_pend_d;
            irq_flag_q     <= irq_flag_d;
            irq_meta_q     <= irq_i;
            irq_sync_q     <= irq_meta_q;
            irq_prev_q     <= irq_sync_q;
        end
    end

`ifdef RTC_SCHED_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              err_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            req_q        <= REQ_RD;
            xfer_start_q <= 1'b0;
            xfer_rw_q    <= 1'b0;
            xfer_addr_q  <= 8'h00;
            xfer_wdata_q <= 8'h00;
            wr_ack_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_index_q   <= 4'd0;
            rd_data_q    <= 8'h00;
`ifdef RTC_SCHED_TIMEOUT_EN
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        state_q      <= S_ISSUE;
                        req_q        <= grant_req;
                        xfer_start_q <= 1'b1;
                        xfer_rw_q    <= grant_rw;
                        xfer_addr_q  <= grant_addr;
                        xfer_wdata_q <= grant_wdata;
                    end
                end
                S_ISSUE: begin
                    xfer_start_q <= 1'b0;
                    state_q      <= S_WAIT;
`ifdef RTC_SCHED_TIMEOUT_EN
                    wait_cnt_q   <= '0;
`endif
                end
                S_WAIT: begin
                    if (xfer_done_i) begin
                        state_q <= S_DONE;
                        if (req_q == REQ_WR) wr_ack_q <= 1'b1;
                        if (req_q == REQ_RD) begin
                            rd_valid_q <= 1'b1;
                            rd_index_q <= burst_idx_q;
                            rd_data_q  <= xfer_rdata_i;
                        end
`ifdef RTC_SCHED_TIMEOUT_EN
                    end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort without completion; the requester's pending state is untouched, so it retries.
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
`endif
                    end
                end
                default: begin
                    wr_ack_q   <= 1'b0;
                    rd_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign xfer_start_o = xfer_start_q;
    assign xfer_rw_o    = xfer_rw_q;
    assign xfer_addr_o  = xfer_addr_q;
    assign xfer_wdata_o = xfer_wdata_q;
    assign wr_ack_o     = wr_ack_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_index_o   = rd_index_q;
    assign rd_data_o    = rd_data_q;
    assign irq_flag_o   = irq_flag_q;
    assign busy_o       = (state_q != S_IDLE);
`ifdef RTC_SCHED_TIMEOUT_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif
endmodule

// File: doc/rtc_access_scheduler.md
# rtc_access_scheduler

Arbitrates and sequences all accesses to the RTC bus transfer engine. Three requesters share the engine: a periodic refresh burst that reads the nine time/timer registers, user write requests from the menu FSM, and RTC IRQ service. The scheduler sits between the menu control, the transfer engine and the display register file. It issues one transfer at a time and routes read data to indexed register slots.

## Interface
Parameters:
- REFRESH_CYCLES, 10_000_000: CLK cycles between refresh-burst triggers (0.1 s at 100 MHz).
- IRQ_ADDR, 8'h00: RTC address written during IRQ service.
- IRQ_DATA, 8'h00: value written during IRQ service.
- TIMEOUT_CYCLES, 4096: watchdog limit on waiting for the transfer engine (only with RTC_SCHED_TIMEOUT_EN).

Ports:
- CLK in 1: system clock, all logic on rising edge.
- RST in 1: asynchronous, active-low reset.
- wr_req in 1: user write request; held high until wr_ack.
- wr_addr in 8, wr_data in 8: write target and data; stable while wr_req is high.
- wr_ack out 1: one-cycle pulse when the user write completes.
- irq in 1: RTC IRQ, active-high, asynchronous; synchronized by 2 flops inside the block.
- xfer_start out 1: one-cycle start pulse to the transfer engine.
- xfer_rw out 1: 1 = read, 0 = write.
- xfer_addr out 8, xfer_wdata out 8: transfer address and write data.
- xfer_done in 1: one-cycle completion pulse from the engine.
- xfer_rdata in 8: read data, valid with xfer_done.
- rd_valid out 1, rd_index out 4, rd_data out 8: register-file write strobe, slot 0–8, and data.
- irq_flag out 1: set on IRQ service completion; cleared by the next completed refresh burst.
- busy out 1: high in any state other than IDLE.
- err out 1: sticky timeout flag (0 when the macro is absent).

## Operation
- Read address table: index 0–5 maps to 8'h21–8'h26 (sec, min, hour, day, month, year). Index 6–8 maps to 8'h41–8'h43 (timer sec, min, hour).
- Refresh counter counts 0..REFRESH_CYCLES-1 and wraps.
  - On wrap it sets refresh_pend and clears burst_idx to 0, unless a burst is already in progress; in that case the trigger is dropped.
- IRQ: a rising edge of the synchronized irq sets irq_pend. Further edges while irq_pend is set merge into it.
- FSM states:
  - IDLE:
    - Arbitrates with priority irq_pend > wr_req > refresh_pend, then goes to ISSUE.
    - Stays in IDLE if nothing is pending.
  - ISSUE (1 cycle):
    - Drives xfer_start=1 and latches xfer_rw/xfer_addr/xfer_wdata for the selected requester.
    - Goes to WAIT.
  - WAIT:
    - Holds xfer_* outputs stable.
    - On xfer_done goes to DONE. xfer_done is ignored in every other state.
  - DONE (1 cycle) performs the completion action for the requester, then returns to IDLE:
    - IRQ: clear irq_pend, set irq_flag.
    - User write: wr_ack=1.
    - Refresh read: rd_valid=1, rd_index=burst_idx, rd_data=captured xfer_rdata; increment burst_idx. At burst_idx 8, clear refresh_pend and irq_flag.
- Preemption:
  - Arbitration reruns between every transfer, so IRQ and user writes interleave into a burst.
  - The burst resumes at the saved burst_idx.
- Reset, including mid-transfer: every output is 0, the FSM goes to IDLE, and all pending flags, the counter and burst_idx clear. The transfer engine shares RST.

## Timing
- Grant latency from IDLE with a request present: xfer_start asserts on the next cycle.
- Minimum transfer cost: ISSUE + WAIT(≥1) + DONE + IDLE = 4 cycles.
- irq-to-pend latency: 3 cycles (2-flop synchronizer plus edge register).
- wr_ack and rd_valid pulse exactly one cycle after the cycle in which xfer_done is sampled.
- Simultaneous refresh wrap and burst completion in the same cycle: completion clears refresh_pend first, then the wrap sets it again. A new burst starts at index 0.

## Configuration
- RTC_SCHED_TIMEOUT_EN defined: a WAIT-state counter runs.
  - When it reaches TIMEOUT_CYCLES without xfer_done, the FSM goes to IDLE and sets err (sticky until reset).
  - The aborted requester stays pending and is retried. No wr_ack or rd_valid is generated for the aborted transfer.
- Macro undefined: no counter exists, WAIT holds indefinitely, and err is tied to 0.

## Test plan
- Reset with RST=0 mid-WAIT → all outputs 0, busy=0. After release, the first xfer_start comes from the refresh trigger at cycle REFRESH_CYCLES.
- Refresh only, engine returning data 8'h10+idx after 3 cycles → nine rd_valid pulses with index 0..8, data 8'h10..8'h18, addresses 8'h21..8'h26, 8'h41..8'h43.
- wr_req with addr 8'h22, data 8'h45 raised during burst index 3 → after the current read, a write to 8'h22/8'h45 issues and wr_ack pulses. The burst then resumes at index 4.
- irq and wr_req asserted in the same cycle while IDLE → IRQ write to IRQ_ADDR/IRQ_DATA issues first, then the user write; irq_flag=1 until the next burst completes.
- With RTC_SCHED_TIMEOUT_EN and the engine never asserting xfer_done → err=1 after TIMEOUT_CYCLES in WAIT, the same read address reissues, and no rd_valid is generated.
